// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing the single-port 8192x32 CPU memory between the
// Nios data master (m0) and the DMA/display fetch master (m1).
module cpu_mem_arbiter #(
    parameter int QUANTUM = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_reset_req,

    input  logic [12:0] m0_address,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,

    input  logic [12:0] m1_address,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,

    output logic [12:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata
);

    localparam logic [3:0] QCAP = 4'(QUANTUM);

    logic       own_q, own_d;
    logic [3:0] qcnt_q, qcnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_tag_q, rd_tag_d;

    logic req0, req1;
    logic gnt0, gnt1;
    logic granted, gsel, sel_write;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!mem_reset_req) begin
            if (req0 && req1) begin
                // Owner keeps the bus until its quantum is spent, then hands over.
                if (qcnt_q < QCAP) begin
                    gnt0 = ~own_q;
                    gnt1 = own_q;
                end else begin
                    gnt0 = own_q;
                    gnt1 = ~own_q;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign granted   = gnt0 | gnt1;
    assign gsel      = gnt1;
    assign sel_write = gsel ? m1_write : m0_write;

    // Idle cycles still drive m0's command fields; chipselect qualifies them.
    assign mem_address    = gsel ? m1_address    : m0_address;
    assign mem_byteenable = gsel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gsel ? m1_writedata  : m0_writedata;
    assign mem_chipselect = granted;
    assign mem_write      = granted & sel_write;
    assign mem_clken      = ~mem_reset_req;

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    always_comb begin
        own_d     = own_q;
        qcnt_d    = qcnt_q;
        rd_pend_d = 1'b0;
        rd_tag_d  = rd_tag_q;
        if (granted) begin
            if (gsel == own_q) begin
                qcnt_d = (qcnt_q == 4'hF) ? qcnt_q : qcnt_q + 4'd1;
            end else begin
                own_d  = gsel;
                qcnt_d = 4'd1;
            end
            // A simultaneous read+write is a write; only pure reads return data.
            rd_pend_d = ~sel_write;
            rd_tag_d  = gsel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            own_q     <= 1'b0;
            qcnt_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
        end else begin
            own_q     <= own_d;
            qcnt_q    <= qcnt_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Memory q is unregistered, so the return is not gated by mem_clken.
    assign m0_readdatavalid = rd_pend_q & ~rd_tag_q;
    assign m1_readdatavalid = rd_pend_q &  rd_tag_q;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
